fpu_round_pack: RTL and testbench

FPU_ROUND_PACK -- requirements
Module: fpu_round_pack

---
 rtl/fpu_round_pack.sv | 193 +++++++++++++++++++
 tb/tb_fpu_round_pack.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_round_pack.sv
// Round-and-pack back end for single-precision add: two-stage valid/ready pipe.
// Define FPU_ROUND_FLAGS_EN to add out_flags {NV,DZ,OF,UF,NX} and its registers.
module fpu_round_pack #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [23:0] in_mantissa,
    input  logic [2:0]  in_guard,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic [2:0]  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FPU_ROUND_FLAGS_EN
    ,
    output logic [4:0]  out_flags
`endif
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic        s1_v_q, s1_v_d;
    logic        s2_v_q, s2_v_d;
    logic        s1_adv, s2_adv, in_fire;

    logic        s1_sign_q, s1_sign_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [24:0] s1_sig_q, s1_sig_d;
    logic [2:0]  s1_mode_q, s1_mode_d;
    logic        s1_nan_q, s1_nan_d;
    logic        s1_inf_q, s1_inf_d;
    logic        s1_zero_q, s1_zero_d;
    logic [31:0] s2_res_q, s2_res_d;
`ifdef FPU_ROUND_FLAGS_EN
    logic        s1_nx_q, s1_nx_d;
    logic [4:0]  s2_flg_q, s2_flg_d;
`endif

    logic        inexact, incr;
    logic [2:0]  mode_n;

    logic        carry, ovf;
    logic [23:0] sig;
    logic [8:0]  exp9;
    logic [7:0]  exp_f;
    logic [31:0] inf_w, max_w, ovf_w;

    assign s2_adv     = !s2_v_q || out_ready;
    assign s1_adv     = !s1_v_q || s2_adv;
    assign in_ready   = s1_adv;
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = s2_v_q;
    assign out_result = s2_res_q;
`ifdef FPU_ROUND_FLAGS_EN
    assign out_flags  = s2_flg_q;
`endif

    always_comb begin
        inexact = |in_guard;
        mode_n  = (in_mode > RM_RMM) ? RM_RNE : in_mode;
        incr    = 1'b0;
        unique case (mode_n)
            RM_RTZ:  incr = 1'b0;
            RM_RDN:  incr = in_sign && inexact;
            RM_RUP:  incr = !in_sign && inexact;
            RM_RMM:  incr = in_guard[2];
            default: incr = in_guard[2] && (|in_guard[1:0] || in_mantissa[0]);
        endcase
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_sign_d = s1_sign_q;
        s1_exp_d  = s1_exp_q;
        s1_sig_d  = s1_sig_q;
        s1_mode_d = s1_mode_q;
        s1_nan_d  = s1_nan_q;
        s1_inf_d  = s1_inf_q;
        s1_zero_d = s1_zero_q;
`ifdef FPU_ROUND_FLAGS_EN
        s1_nx_d   = s1_nx_q;
`endif
        if (s1_adv) s1_v_d = in_fire;
        if (in_fire) begin
            s1_sign_d = in_sign;
            s1_exp_d  = in_exponent;
            s1_sig_d  = {1'b0, in_mantissa} + {24'd0, incr};
            s1_mode_d = mode_n;
            s1_nan_d  = in_nan;
            s1_inf_d  = in_inf;
            s1_zero_d = (in_mantissa == 24'd0) && !inexact;
`ifdef FPU_ROUND_FLAGS_EN
            s1_nx_d   = inexact;
`endif
        end
    end

    // Carry-out renormalises by one place; overflow picks inf or max-finite by direction.
    always_comb begin
        carry = s1_sig_q[24];
        sig   = carry ? s1_sig_q[24:1] : s1_sig_q[23:0];
        exp9  = {1'b0, s1_exp_q} + {8'd0, carry};
        ovf   = exp9 >= 9'd255;
        exp_f = sig[23] ? exp9[7:0] : 8'd0;
        inf_w = {s1_sign_q, 8'hFF, 23'd0};
        max_w = {s1_sign_q, 8'hFE, {23{1'b1}}};
        ovf_w = inf_w;
        unique case (s1_mode_q)
            RM_RTZ:  ovf_w = max_w;
            RM_RDN:  ovf_w = s1_sign_q ? inf_w : max_w;
            RM_RUP:  ovf_w = s1_sign_q ? max_w : inf_w;
            default: ovf_w = inf_w;
        endcase
    end

    always_comb begin
        s2_v_d   = s2_v_q;
        s2_res_d = s2_res_q;
`ifdef FPU_ROUND_FLAGS_EN
        s2_flg_d = s2_flg_q;
`endif
        if (s2_adv) s2_v_d = s1_v_q;
        if (s2_adv && s1_v_q) begin
            if (s1_nan_q) begin
                s2_res_d = CANON_NAN;
            end else if (s1_inf_q) begin
                s2_res_d = inf_w;
            end else if (ovf) begin
                s2_res_d = ovf_w;
            end else if (s1_zero_q) begin
                s2_res_d = {s1_sign_q, 31'd0};
            end else begin
                s2_res_d = {s1_sign_q, exp_f, sig[22:0]};
            end
`ifdef FPU_ROUND_FLAGS_EN
            if (s1_nan_q || s1_inf_q) begin
                s2_flg_d = 5'b00000;
            end else if (ovf) begin
                s2_flg_d = 5'b00101;
            end else if (s1_zero_q) begin
                s2_flg_d = 5'b00000;
            end else begin
                s2_flg_d = {3'b000, s1_nx_q && (exp_f == 8'd0), s1_nx_q};
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= 8'd0;
            s1_sig_q  <= 25'd0;
            s1_mode_q <= RM_RNE;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s2_res_q  <= 32'd0;
`ifdef FPU_ROUND_FLAGS_EN
            s1_nx_q   <= 1'b0;
            s2_flg_q  <= 5'd0;
`endif
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_sig_q  <= s1_sig_d;
            s1_mode_q <= s1_mode_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_zero_q <= s1_zero_d;
            s2_res_q  <= s2_res_d;
`ifdef FPU_ROUND_FLAGS_EN
            s1_nx_q   <= s1_nx_d;
            s2_flg_q  <= s2_flg_d;
`endif
        end
    end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Self-checking bench for fpu_round_pack: arithmetic reference model + scoreboard.
// Flags are compared against the DUT only when FPU_ROUND_FLAGS_EN is defined.
module tb_fpu_round_pack;

    localparam logic [31:0] CNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [23:0] in_mantissa;
    logic [2:0]  in_guard;
    logic        in_nan, in_inf;
    logic [2:0]  in_mode;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
`ifdef FPU_ROUND_FLAGS_EN
    logic [4:0]  out_flags;
`endif

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    logic [36:0] sb[$];
    bit tog_run = 0;

    fpu_round_pack #(.CANON_NAN(CNAN)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sign(in_sign),
        .in_exponent(in_exponent),
        .in_mantissa(in_mantissa),
        .in_guard(in_guard),
        .in_nan(in_nan),
        .in_inf(in_inf),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result)
`ifdef FPU_ROUND_FLAGS_EN
        ,
        .out_flags(out_flags)
`endif
    );

    always #5 clk = ~clk;

    // Reference: value = mant + guard/8 ulp; round, renormalise, classify.
    function automatic logic [36:0] model(input logic s, input logic [7:0] e,
                                          input logic [23:0] m, input logic [2:0] g,
                                          input logic [2:0] md, input logic nn,
                                          input logic nf);
        int unsigned q;
        int unsigned r;
        int ex;
        int mode;
        bit up;
        bit nx;
        bit toinf;
        logic [31:0] res;
        logic [4:0]  fl;
        logic [7:0]  fe;
        logic [31:0] qv;
        mode = (int'(md) > 4) ? 0 : int'(md);
        q  = 32'(m);
        r  = 32'(g);
        nx = (r != 0);
        if (nn) return {CNAN, 5'd0};
        if (nf) return {s, 8'hFF, 23'd0, 5'd0};
        case (mode)
            0: up = (r > 4) || (r == 4 && (q % 2) == 1);
            1: up = 0;
            2: up = s && (r != 0);
            3: up = !s && (r != 0);
            default: up = (r >= 4);
        endcase
        q  = q + (up ? 1 : 0);
        ex = int'(e);
        if (q >= 32'h0100_0000) begin
            q  = q / 2;
            ex = ex + 1;
        end
        if (ex >= 255) begin
            case (mode)
                1: toinf = 0;
                2: toinf = s;
                3: toinf = !s;
                default: toinf = 1;
            endcase
            res = toinf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
            fl  = 5'b00101;
        end else if (m == 24'd0 && g == 3'd0) begin
            res = {s, 31'd0};
            fl  = 5'd0;
        end else begin
            fe  = (q >= 32'h0080_0000) ? 8'(ex) : 8'd0;
            qv  = q;
            res = {s, fe, qv[22:0]};
            fl  = {3'b000, nx && (fe == 8'd0), nx};
        end
        return {res, fl};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard, hold check and output compare, all sampled on the falling edge.
    initial begin
        logic [36:0] e;
        bit held_v;
        logic [31:0] held_r;
        held_v = 0;
        held_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                held_v = 0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_result", out_result, held_r);
                end
                held_v = out_valid && !out_ready;
                held_r = out_result;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h want none", out_result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", out_result, e[36:5]);
`ifdef FPU_ROUND_FLAGS_EN
                        chk("flags", 32'(out_flags), 32'(e[4:0]));
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(model(in_sign, in_exponent, in_mantissa, in_guard,
                                       in_mode, in_nan, in_inf));
                    n_acc++;
                end
            end
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                        input logic [2:0] g, input logic [2:0] md,
                        input logic nn, input logic nf);
        bit done;
        done        = 0;
        in_valid    = 1'b1;
        in_sign     = s;
        in_exponent = e;
        in_mantissa = m;
        in_guard    = g;
        in_mode     = md;
        in_nan      = nn;
        in_inf      = nf;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic s, input logic [7:0] e,
                       input logic [23:0] m, input logic [2:0] g, input logic [2:0] md,
                       input logic nn, input logic [31:0] res, input logic [4:0] fl);
        logic [36:0] x;
        x = model(s, e, m, g, md, nn, 1'b0);
        chk({name, "_res"}, x[36:5], res);
        chk({name, "_flg"}, 32'(x[4:0]), 32'(fl));
        send(s, e, m, g, md, nn, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [35:0] tbl [12] = '{
        {1'b0, 8'd130, 24'hC00000, 3'b000},
        {1'b1, 8'd100, 24'hABCDEF, 3'b101},
        {1'b0, 8'd10,  24'h800001, 3'b100},
        {1'b1, 8'd1,   24'h7FFFFF, 3'b111},
        {1'b0, 8'd1,   24'h000003, 3'b010},
        {1'b1, 8'd254, 24'hFFFFFF, 3'b100},
        {1'b0, 8'd254, 24'hFFFFFF, 3'b001},
        {1'b1, 8'd255, 24'h900000, 3'b000},
        {1'b0, 8'd0,   24'h000000, 3'b000},
        {1'b1, 8'd200, 24'h000000, 3'b000},
        {1'b0, 8'd127, 24'hFFFFFE, 3'b110},
        {1'b1, 8'd50,  24'h800000, 3'b011}
    };

    initial begin
        logic [35:0] v;
        logic [15:0] pat;
        int base;
        bit sawv;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = 8'd0;
        in_mantissa = 24'd0;
        in_guard    = 3'd0;
        in_nan      = 1'b0;
        in_inf      = 1'b0;
        in_mode     = 3'd0;
        out_ready   = 1'b1;
        idle(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        lit("rne_tie", 1'b0, 8'd127, 24'h800001, 3'b100, 3'd0, 1'b0, 32'h3F800002, 5'b00001);
        lit("carry", 1'b0, 8'd127, 24'hFFFFFF, 3'b100, 3'd0, 1'b0, 32'h40000000, 5'b00001);
        lit("ovf_rne", 1'b0, 8'd255, 24'h800000, 3'b000, 3'd0, 1'b0, 32'h7F800000, 5'b00101);
        lit("ovf_rtz", 1'b0, 8'd255, 24'h800000, 3'b000, 3'd1, 1'b0, 32'h7F7FFFFF, 5'b00101);
        lit("ovf_rdn_n", 1'b1, 8'd255, 24'h800000, 3'b000, 3'd2, 1'b0, 32'hFF800000, 5'b00101);
        lit("ovf_rdn_p", 1'b0, 8'd255, 24'h800000, 3'b000, 3'd2, 1'b0, 32'h7F7FFFFF, 5'b00101);
        lit("ovf_rup_n", 1'b1, 8'd255, 24'h800000, 3'b000, 3'd3, 1'b0, 32'hFF7FFFFF, 5'b00101);
        lit("sub_rne", 1'b0, 8'd1, 24'h7FFFFF, 3'b100, 3'd0, 1'b0, 32'h00800000, 5'b00001);
        lit("sub_rtz", 1'b0, 8'd1, 24'h7FFFFF, 3'b011, 3'd1, 1'b0, 32'h007FFFFF, 5'b00011);
        lit("nan", 1'b1, 8'd3, 24'h812345, 3'b101, 3'd0, 1'b1, 32'h7FC00000, 5'b00000);
        lit("neg_zero", 1'b1, 8'd50, 24'h000000, 3'b000, 3'd3, 1'b0, 32'h80000000, 5'b00000);
        lit("rmm_half", 1'b0, 8'd127, 24'h800000, 3'b100, 3'd4, 1'b0, 32'h3F800001, 5'b00001);
        lit("mode7_rne", 1'b0, 8'd127, 24'h800000, 3'b100, 3'd7, 1'b0, 32'h3F800000, 5'b00001);
        send(1'b1, 8'd9, 24'h800000, 3'b000, 3'd0, 1'b0, 1'b1);
        idle(4);

        for (int md = 0; md < 8; md++) begin
            for (int i = 0; i < 12; i++) begin
                v = tbl[i];
                send(v[35], v[34:27], v[26:3], v[2:0], 3'(md), 1'b0, 1'b0);
            end
        end
        idle(4);

        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                send(1'b0, 8'd127, 24'h800001, 3'b100, 3'd0, 1'b0, 1'b0);
                send(1'b1, 8'd128, 24'hA00000, 3'b111, 3'd2, 1'b0, 1'b0);
                send(1'b0, 8'd1,   24'h7FFFFF, 3'b011, 3'd1, 1'b0, 1'b0);
                send(1'b1, 8'd255, 24'h800000, 3'b000, 3'd3, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_accepted", 32'(n_acc - base), 32'd2);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("bp_all_out", 32'(n_acc - base), 32'd4);

        pat = 16'b1100_1010_0111_0010;
        tog_run = 1;
        fork
            begin
                int k;
                k = 0;
                while (tog_run) begin
                    out_ready = pat[k % 16];
                    k++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 12; i++) begin
            v = tbl[i];
            send(v[35], v[34:27], v[26:3], v[2:0], 3'(i % 5), i == 7, i == 3);
        end
        tog_run = 0;
        idle(2);
        out_ready = 1'b1;
        idle(8);

        send(1'b0, 8'd127, 24'hC00000, 3'b000, 3'd0, 1'b0, 1'b0);
        send(1'b1, 8'd130, 24'h900001, 3'b100, 3'd0, 1'b0, 1'b0);
        chk("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", out_result, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
        sawv = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) sawv = 1;
        end
        chk("no_stale", 32'(sawv), 32'd0);
        @(posedge clk);
        #1;
        send(1'b0, 8'd127, 24'h800000, 3'b001, 3'd3, 1'b0, 1'b0);
        idle(6);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
